// File: rtl/uart_transmitter_if.sv
// Byte handshake between a client and uart_transmitter.
// The client drives i_valid/i_bin and the transmitter drives o_ready.
interface uart_transmitter_if;
  logic       i_valid;
  logic [7:0] i_bin;
  logic       o_ready;

  modport master (output i_valid, output i_bin, input o_ready);
  modport slave  (input i_valid, input i_bin, output o_ready);
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1, LSB first, idle-high line; UART_TX_PARITY_EN adds an even-parity bit.
// Latency: start bit on the cycle after accept, each bit BAUD_PERIOD cycles, o_done on the first IDLE cycle.
// Backpressure: o_ready only in IDLE; valid while busy is ignored, with no queueing.
module uart_transmitter #(
  parameter int BAUD_RATE = 115200,
  parameter int CLK_FREQ  = 25000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  uart_transmitter_if.slave tx_if,
  output logic              o_uart,
  output logic              o_busy,
  output logic              o_done
);
  localparam int BAUD_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W       = $clog2(BAUD_PERIOD) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(BAUD_PERIOD - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             uart_q, uart_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic accept;
  logic bit_end;

  assign tx_if.o_ready = (state_q == IDLE) && !i_rst;
  assign accept        = tx_if.i_valid && tx_if.o_ready;
  assign bit_end       = (cnt_q == '0);

  // uart_d always carries the level of the bit that starts next cycle, so the line is a clean flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    uart_d   = uart_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? CNT_RELOAD : cnt_q - 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        uart_d = 1'b1;
        if (accept) begin
          state_d  = START;
          shift_d  = tx_if.i_bin;
          cnt_d    = CNT_RELOAD;
          idx_d    = '0;
          uart_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_if.i_bin;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          uart_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            uart_d  = parity_q;
`else
            state_d = STOP;
            uart_d  = 1'b1;
`endif
          end else begin
            idx_d  = idx_q + 3'd1;
            uart_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          uart_d  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          uart_d  = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        uart_d  = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      uart_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      uart_q   <= uart_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_uart = uart_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
